// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
// Shared types and constants for the RTC parallel bus interface:
//   rtc_state_e          - bus sequencer states
//   rtc_op_e             - transaction type latched at accept
//   PHASE_CYCLES_DEFAULT - default clock cycles per bus phase
package rtc_bus_pkg;

    localparam int PHASE_CYCLES_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_STB = 3'd1,
        A_REL = 3'd2,
        D_STB = 3'd3,
        D_REL = 3'd4,
        DONE  = 3'd5
    } rtc_state_e;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } rtc_op_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer
// Down-counter that times one bus phase. A load starts it at
// PHASE_CYCLES-1; it then counts down to 0 and stays there. With count
// low it is cleared to 0 (sequencer idle).
// Ports:
//   clock   - system clock
//   reset   - asynchronous active-low reset
//   load    - reload to PHASE_CYCLES-1 (sequencer changing state)
//   count   - decrement enable; low forces the counter to 0
//   expired - counter is 0, i.e. this is the last cycle of the phase
module rtc_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam logic [7:0] RELOAD = 8'(PHASE_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (!count) begin
            cnt <= 8'd0;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expired = (cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_if.sv
// rtc_bus_if
// Sequencer for a multiplexed-address/data RTC bus. A write or read
// request is run as address strobe, address release, data strobe, data
// release (PHASE_CYCLES each) and a one-cycle DONE with a done pulse.
// Optional feature macro: RTC_BUS_PENDING_EN adds a one-entry slot that
// holds the first request arriving while busy and starts it right after
// DONE. Without it, requests seen while busy are dropped.
// Ports:
//   clock, reset          - system clock, async active-low reset
//   win, rin              - write / read request pulses (write wins)
//   addressin, datain     - register address and write data
//   ad_in                 - bus value, sampled at end of read data strobe
//   ad_out, ad_oe         - bus drive value and enable
//   AD, CS, RD, WR        - AD: 0 addr / 1 data phase; others active low
//   dataout               - last read data
//   donew, doner, busy    - write done, read done pulses; busy status
module rtc_bus_if
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       win,
    input  logic       rin,
    input  logic [7:0] addressin,
    input  logic [7:0] datain,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [7:0] dataout,
    output logic       donew,
    output logic       doner,
    output logic       busy
);

    rtc_state_e state, state_nxt;
    rtc_op_e    op_q, op_nxt, req_op;
    logic [7:0] addr_q, addr_nxt, data_q, data_nxt, req_addr, req_data;
    logic       req_take, expired, load, count;

    // next values for the registered bus outputs
    logic       ad_nx, cs_nx, wr_nx, rd_nx, oe_nx, donew_nx, doner_nx;
    logic [7:0] out_nx;

`ifdef RTC_BUS_PENDING_EN
    logic       pend_valid;
    rtc_op_e    pend_op;
    logic [7:0] pend_addr, pend_data;

    // The slot drains in IDLE; a request arriving in that same cycle
    // refills it, since the sequencer is busy again from the next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_op    <= OP_WRITE;
            pend_addr  <= 8'h00;
            pend_data  <= 8'h00;
        end else if ((state == IDLE && pend_valid) ||
                     (state != IDLE && !pend_valid)) begin
            pend_valid <= win | rin;
            if (win | rin) begin
                pend_op   <= win ? OP_WRITE : OP_READ;
                pend_addr <= addressin;
                pend_data <= datain;
            end
        end
    end
`endif

    always_comb begin
        req_take = win | rin;
        req_op   = win ? OP_WRITE : OP_READ;
        req_addr = addressin;
        req_data = datain;
`ifdef RTC_BUS_PENDING_EN
        if (pend_valid) begin
            req_take = 1'b1;
            req_op   = pend_op;
            req_addr = pend_addr;
            req_data = pend_data;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        case (state)
            IDLE: if (req_take) begin
                state_nxt = A_STB;
                op_nxt    = req_op;
                addr_nxt  = req_addr;
                data_nxt  = req_data;
            end
            A_STB:   if (expired) state_nxt = A_REL;
            A_REL:   if (expired) state_nxt = D_STB;
            D_STB:   if (expired) state_nxt = D_REL;
            D_REL:   if (expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that, once registered,
    // they line up with the state they describe.
    always_comb begin
        ad_nx    = 1'b1;
        cs_nx    = 1'b1;
        wr_nx    = 1'b1;
        rd_nx    = 1'b1;
        oe_nx    = 1'b0;
        out_nx   = 8'h00;
        donew_nx = 1'b0;
        doner_nx = 1'b0;
        case (state_nxt)
            A_STB: begin
                ad_nx  = 1'b0;
                cs_nx  = 1'b0;
                wr_nx  = 1'b0;
                oe_nx  = 1'b1;
                out_nx = addr_nxt;
            end
            A_REL: begin
                ad_nx  = 1'b0;
                oe_nx  = 1'b1;
                out_nx = addr_nxt;
            end
            D_STB: begin
                cs_nx = 1'b0;
                if (op_nxt == OP_WRITE) begin
                    wr_nx  = 1'b0;
                    oe_nx  = 1'b1;
                    out_nx = data_nxt;
                end else begin
                    rd_nx = 1'b0;
                end
            end
            D_REL: if (op_nxt == OP_WRITE) begin
                oe_nx  = 1'b1;
                out_nx = data_nxt;
            end
            DONE: begin
                donew_nx = (op_nxt == OP_WRITE);
                doner_nx = (op_nxt == OP_READ);
            end
            default: ;
        endcase
    end

    assign load  = (state_nxt != state) && (state_nxt != IDLE);
    assign count = (state_nxt != IDLE);

    rtc_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .count   (count),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= OP_WRITE;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            AD      <= 1'b1;
            CS      <= 1'b1;
            RD      <= 1'b1;
            WR      <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
            dataout <= 8'h00;
            donew   <= 1'b0;
            doner   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            AD     <= ad_nx;
            CS     <= cs_nx;
            RD     <= rd_nx;
            WR     <= wr_nx;
            ad_oe  <= oe_nx;
            ad_out <= out_nx;
            donew  <= donew_nx;
            doner  <= doner_nx;
            busy   <= (state_nxt != IDLE);
            if (state == D_STB && expired && op_q == OP_READ) begin
                dataout <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_if.sv
module tb_rtc_bus_if;

    localparam int P        = 4;
    localparam int DONE_CYC = 4 * P + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       win = 1'b0, rin = 1'b0;
    logic [7:0] addressin = 8'h00, datain = 8'h00, ad_in = 8'h00;
    logic [7:0] ad_out, dataout;
    logic       ad_oe, AD, CS, RD, WR, donew, doner, busy;

    rtc_bus_if #(.PHASE_CYCLES(P)) dut (
        .clock     (clock),
        .reset     (reset),
        .win       (win),
        .rin       (rin),
        .addressin (addressin),
        .datain    (datain),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .AD        (AD),
        .CS        (CS),
        .RD        (RD),
        .WR        (WR),
        .dataout   (dataout),
        .donew     (donew),
        .doner     (doner),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       is_write;
        logic [7:0] dout;
    } exp_t;

    typedef struct {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd;
    } op_t;

    exp_t       sb[$];
    op_t        ops[3];
    int         pass_cnt = 0;
    int         check_cnt = 0;
    logic [7:0] last_rd = 8'h00;

    // Request is sampled by the next rising edge (accept cycle = cycle 0);
    // returns just after that edge, so the next falling edge is cycle 1.
    task automatic issue(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        win = w; rin = r; addressin = a; datain = d;
        @(posedge clock);
        #1;
        win = 1'b0; rin = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_cnt++;
        if ({AD, CS, RD, WR, ad_oe, donew, doner, busy} !== 8'b1111_0000)
            $display("FAIL reset_ctrl actual=%b expected=%b", {AD, CS, RD, WR, ad_oe, donew, doner, busy}, 8'b1111_0000);
        else pass_cnt++;
        check_cnt++;
        if ({ad_out, dataout} !== 16'h0000)
            $display("FAIL reset_data actual=%h expected=0000", {ad_out, dataout});
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_single_ops();
        exp_t e;
        logic astb, arel, dstb, drel, w;
        logic [7:0] e_ctrl, e_out;
        ops[0] = '{1'b1, 8'h21, 8'h15, 8'h00};
        ops[1] = '{1'b0, 8'h22, 8'h00, 8'h47};
        ops[2] = '{1'b1, 8'hA5, 8'h3C, 8'h00};
        for (int i = 0; i < 3; i++) begin
            w = ops[i].is_write;
            if (w) sb.push_back('{1'b1, last_rd});
            else begin
                sb.push_back('{1'b0, ops[i].rd});
                last_rd = ops[i].rd;
            end
            ad_in = ~ops[i].rd;
            issue(w, ~w, ops[i].addr, ops[i].data);
            for (int c = 1; c <= DONE_CYC + 1; c++) begin
                @(negedge clock);
                astb = (c >= 1) && (c <= P);
                arel = (c > P) && (c <= 2 * P);
                dstb = (c > 2 * P) && (c <= 3 * P);
                drel = (c > 3 * P) && (c <= 4 * P);
                e_ctrl = {!(astb || arel), !(astb || dstb), !(astb || (dstb && w)),
                          !(dstb && !w), astb || arel || ((dstb || drel) && w),
                          c <= DONE_CYC, (c == DONE_CYC) && w, (c == DONE_CYC) && !w};
                e_out = (astb || arel) ? ops[i].addr :
                        ((dstb || drel) && w) ? ops[i].data : 8'h00;
                check_cnt++;
                if ({AD, CS, WR, RD, ad_oe, busy, donew, doner} !== e_ctrl)
                    $display("FAIL op%0d_ctrl_c%0d actual=%b expected=%b", i, c,
                             {AD, CS, WR, RD, ad_oe, busy, donew, doner}, e_ctrl);
                else pass_cnt++;
                check_cnt++;
                if (ad_out !== e_out)
                    $display("FAIL op%0d_adout_c%0d actual=%h expected=%h", i, c, ad_out, e_out);
                else pass_cnt++;
                if ((donew || doner) && sb.size() > 0) begin
                    e = sb.pop_front();
                    check_cnt++;
                    if (dataout !== e.dout)
                        $display("FAIL op%0d_dataout actual=%h expected=%h", i, dataout, e.dout);
                    else pass_cnt++;
                end
                ad_in = (c == 3 * P) ? ops[i].rd : ~ops[i].rd;
            end
            check_cnt++;
            if (sb.size() != 0) begin
                $display("FAIL op%0d_done_missing pending=%0d expected=0", i, sb.size());
                sb.delete();
            end else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        int nw = 0, nr = 0;
        exp_t e;
        sb.push_back('{1'b1, last_rd});
        ad_in = 8'hEE;
        issue(1'b1, 1'b1, 8'h10, 8'h5A);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clock);
            if (c == 2 * P + 1) begin
                check_cnt++;
                if ({WR, RD, ad_out} !== {1'b0, 1'b1, 8'h5A})
                    $display("FAIL simul_dstb actual=%b expected=%b", {WR, RD, ad_out}, {1'b0, 1'b1, 8'h5A});
                else pass_cnt++;
            end
            if (donew) nw++;
            if (doner) nr++;
            if ((donew || doner) && sb.size() > 0) begin
                e = sb.pop_front();
                check_cnt++;
                if (dataout !== e.dout)
                    $display("FAIL simul_dataout actual=%h expected=%h", dataout, e.dout);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (nw != 1) $display("FAIL simul_donew_count actual=%0d expected=1", nw);
        else pass_cnt++;
        check_cnt++;
        if (nr != 0) $display("FAIL simul_doner_count actual=%0d expected=0", nr);
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_reset_abort();
        int ndone = 0, done_cyc = -1;
        exp_t e;
        sb.push_back('{1'b1, last_rd});
        issue(1'b1, 1'b0, 8'h33, 8'h44);
        repeat (2 * P + 2) @(negedge clock);
        check_cnt++;
        if ({AD, WR, ad_out} !== {1'b1, 1'b0, 8'h44})
            $display("FAIL abort_pre actual=%b expected=%b", {AD, WR, ad_out}, {1'b1, 1'b0, 8'h44});
        else pass_cnt++;
        #1 reset = 1'b0;
        #1;
        check_cnt++;
        if ({AD, CS, RD, WR, ad_oe, donew, doner, busy, ad_out, dataout} !== {8'b1111_0000, 16'h0000})
            $display("FAIL abort_reset actual=%b expected=%b",
                     {AD, CS, RD, WR, ad_oe, donew, doner, busy, ad_out, dataout}, {8'b1111_0000, 16'h0000});
        else pass_cnt++;
        sb.delete();
        last_rd = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (donew || doner || busy) ndone++;
        end
        check_cnt++;
        if (ndone != 0) $display("FAIL abort_no_done actual=%0d expected=0", ndone);
        else pass_cnt++;
        sb.push_back('{1'b0, 8'h99});
        last_rd = 8'h99;
        ad_in = 8'h99;
        issue(1'b0, 1'b1, 8'h44, 8'h00);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (doner && done_cyc < 0) begin
                done_cyc = c;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_cnt++;
                    if (dataout !== e.dout)
                        $display("FAIL fresh_dataout actual=%h expected=%h", dataout, e.dout);
                    else pass_cnt++;
                end
            end
        end
        check_cnt++;
        if (done_cyc != DONE_CYC) $display("FAIL fresh_done_cycle actual=%0d expected=%0d", done_cyc, DONE_CYC);
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_busy_request();
        int dw = -1, dr = -1, cs_start = -1, busy18 = -1;
        exp_t e;
        ad_in = 8'h6B;
        sb.push_back('{1'b1, last_rd});
`ifdef RTC_BUS_PENDING_EN
        sb.push_back('{1'b0, 8'h6B});
`endif
        issue(1'b1, 1'b0, 8'h30, 8'h77);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            if (c == 5) begin rin = 1'b1; addressin = 8'h31; end
            if (c == 6) rin = 1'b0;
            if (donew && dw < 0) dw = c;
            if (doner && dr < 0) dr = c;
            if (c > DONE_CYC && !CS && cs_start < 0) cs_start = c;
            if (c == DONE_CYC + 1) busy18 = int'(busy);
            if ((donew || doner) && sb.size() > 0) begin
                e = sb.pop_front();
                check_cnt++;
                if (dataout !== e.dout || donew !== e.is_write)
                    $display("FAIL busyreq_pop_c%0d actual=%b/%h expected=%b/%h", c, donew, dataout, e.is_write, e.dout);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (dw != DONE_CYC) $display("FAIL busyreq_write_done actual=%0d expected=%0d", dw, DONE_CYC);
        else pass_cnt++;
`ifdef RTC_BUS_PENDING_EN
        check_cnt++;
        if (cs_start != 19) $display("FAIL busyreq_read_start actual=%0d expected=19", cs_start);
        else pass_cnt++;
        check_cnt++;
        if (dr != 35) $display("FAIL busyreq_read_done actual=%0d expected=35", dr);
        else pass_cnt++;
`else
        check_cnt++;
        if (dr != -1 || cs_start != -1)
            $display("FAIL busyreq_ignored actual=%0d/%0d expected=-1/-1", dr, cs_start);
        else pass_cnt++;
        check_cnt++;
        if (busy18 != 0) $display("FAIL busyreq_idle actual=%0d expected=0", busy18);
        else pass_cnt++;
`endif
        check_cnt++;
        if (sb.size() != 0) $display("FAIL busyreq_sb_left actual=%0d expected=0", sb.size());
        else pass_cnt++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_simultaneous();
        test_reset_abort();
        test_busy_request();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
